// File: rtl/translating_line_animator_pkg.sv
// Shared definitions for the translating line animator.
//   state_e   : sequencer states (IDLE, ERASE, DRAW)
//   CW        : coordinate width of every x/y bus
//   H_RES_DEF : default horizontal resolution
//   V_RES_DEF : default vertical resolution
package translating_line_animator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2
   } state_e;

   localparam int CW        = 11;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

endpackage

// File: rtl/translating_line_animator_line_drawer.sv
// Bresenham line engine, one pixel per cycle, all octants.
//   clk, reset   : clock, synchronous active-high reset
//   start        : load endpoints; first pixel appears the next cycle.
//                  Takes priority over the walk in progress, so a new
//                  line can follow the endpoint cycle back to back.
//   x0,y0,x1,y1  : line endpoints, inclusive
//   x, y         : current pixel
//   valid        : x/y hold a pixel of the line
//   done         : current pixel is the endpoint
module translating_line_animator_line_drawer
   import translating_line_animator_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y1,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          valid,
   output logic          done
);

   // Error term spans roughly +/-2*max(dx,dy); 2*err needs one bit more.
   localparam int EW = CW + 3;
   typedef logic signed [EW-1:0] se_t;
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
   se_t           err_q, err_d, dx_q, dx_d, dy_q, dy_d;
   logic          sxn_q, sxn_d, syn_q, syn_d, busy_q, busy_d;
   se_t           ddx, ddy, adx, ady, e2;
   logic          at_end;

   always_comb begin
      ddx    = se_t'(x1) - se_t'(x0);
      ddy    = se_t'(y1) - se_t'(y0);
      adx    = ddx[EW-1] ? -ddx : ddx;
      ady    = ddy[EW-1] ? -ddy : ddy;
      e2     = err_q <<< 1;
      at_end = busy_q && (x_q == xe_q) && (y_q == ye_q);

      x_d    = x_q;
      y_d    = y_q;
      xe_d   = xe_q;
      ye_d   = ye_q;
      err_d  = err_q;
      dx_d   = dx_q;
      dy_d   = dy_q;
      sxn_d  = sxn_q;
      syn_d  = syn_q;
      busy_d = busy_q;

      if (start) begin
         x_d    = x0;
         y_d    = y0;
         xe_d   = x1;
         ye_d   = y1;
         dx_d   = adx;
         dy_d   = -ady;      // kept negative, as in the classic form
         err_d  = adx - ady;
         sxn_d  = ddx[EW-1];
         syn_d  = ddy[EW-1];
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (at_end) begin
            busy_d = 1'b0;
         end else begin
            if (e2 >= dy_q) begin
               err_d = err_d + dy_q;
               x_d   = sxn_q ? x_q - ONE : x_q + ONE;
            end
            if (e2 <= dx_q) begin
               err_d = err_d + dx_q;
               y_d   = syn_q ? y_q - ONE : y_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         xe_q   <= '0;
         ye_q   <= '0;
         err_q  <= '0;
         dx_q   <= '0;
         dy_q   <= '0;
         sxn_q  <= 1'b0;
         syn_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         xe_q   <= xe_d;
         ye_q   <= ye_d;
         err_q  <= err_d;
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         sxn_q  <= sxn_d;
         syn_q  <= syn_d;
         busy_q <= busy_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign valid = busy_q;
   assign done  = at_end;

endmodule

// File: rtl/translating_line_animator.sv
// Animates a fixed line sliding right across the framebuffer. Each rising
// edge of update_event erases the line at the current offset (color 0),
// then redraws it at the next offset (color 1). Every cycle is a write.
//   clk, reset   : clock, synchronous active-high reset
//   update_event : slow level from the clock divider; rising edge = step
//   x, y         : pixel write coordinate
//   pixel_color  : 1 = white, 0 = black
module translating_line_animator
   import translating_line_animator_pkg::*;
#(
   parameter int X0    = 0,
   parameter int Y0    = 0,
   parameter int X1    = 100,
   parameter int Y1    = 60,
   parameter int DX    = 4,
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          update_event,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          pixel_color
);

   // A misconfigured y would never be written on screen; pin it to the last row.
   localparam int Y0_CL = (Y0 < V_RES) ? Y0 : V_RES - 1;
   localparam int Y1_CL = (Y1 < V_RES) ? Y1 : V_RES - 1;

   localparam logic [CW-1:0] X0_C  = CW'(X0);
   localparam logic [CW-1:0] X1_C  = CW'(X1);
   localparam logic [CW-1:0] Y0_C  = CW'(Y0_CL);
   localparam logic [CW-1:0] Y1_C  = CW'(Y1_CL);
   localparam logic [CW-1:0] DX_C  = CW'(DX);
   localparam logic [CW:0]   X_LIM = (CW+1)'(H_RES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] off_q, off_d;
   logic          ue_q;
   logic [CW-1:0] lx_q, lx_d, ly_q, ly_d;
   logic          lc_q, lc_d;

   logic [CW-1:0] step_sum, nxt_off, st_off;
   logic          step_req, drw_start;
   logic [CW-1:0] drw_x, drw_y;
   logic          drw_valid, drw_done;

   assign step_req = update_event & ~ue_q;
   assign step_sum = off_q + DX_C;
   // Wrap when the translated endpoint would fall off the right edge.
   assign nxt_off  = (({1'b0, X1_C} + {1'b0, step_sum}) > X_LIM) ? '0 : step_sum;
   // The DRAW pass is launched from the ERASE endpoint cycle, before off_q
   // has taken the new value, so it must see nxt_off directly.
   assign st_off   = (state_q == ERASE) ? nxt_off : off_q;

   translating_line_animator_line_drawer u_line_drawer (
      .clk   (clk),
      .reset (reset),
      .start (drw_start),
      .x0    (X0_C + st_off),
      .y0    (Y0_C),
      .x1    (X1_C + st_off),
      .y1    (Y1_C),
      .x     (drw_x),
      .y     (drw_y),
      .valid (drw_valid),
      .done  (drw_done)
   );

   always_comb begin
      state_d   = state_q;
      off_d     = off_q;
      drw_start = 1'b0;
      unique case (state_q)
         IDLE: if (step_req) begin
            drw_start = 1'b1;
            state_d   = ERASE;
         end
         ERASE: if (drw_done) begin
            off_d     = nxt_off;
            drw_start = 1'b1;
            state_d   = DRAW;
         end
         DRAW: if (drw_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: live pixel while walking, otherwise repeat the last write.
   always_comb begin
      lx_d        = lx_q;
      ly_d        = ly_q;
      lc_d        = lc_q;
      x           = lx_q;
      y           = ly_q;
      pixel_color = lc_q;
      if (state_q != IDLE && drw_valid) begin
         x           = drw_x;
         y           = drw_y;
         pixel_color = (state_q == DRAW);
         lx_d        = drw_x;
         ly_d        = drw_y;
         lc_d        = (state_q == DRAW);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         off_q   <= '0;
         ue_q    <= 1'b0;
         lx_q    <= X0_C;
         ly_q    <= Y0_C;
         lc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         ue_q    <= update_event;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
         lc_q    <= lc_d;
      end
   end

endmodule

// File: tb/tb_translating_line_animator.sv
// Bench for translating_line_animator with default parameters. The model
// describes the line as the ideal rounded slope y = round(0.6*i) for
// i = 0..100 at x = offset+i, and the offset as a plain add-and-wrap.
module tb_translating_line_animator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        update_event = 1'b0;
   logic [10:0] x, y;
   logic        pixel_color;

   int n_cmp = 0;
   int n_bad = 0;
   int off_m = 0;
   int drawn = 0;
   int idle_x = 0, idle_y = 0, idle_c = 0;

   always #10 clk = ~clk;

   translating_line_animator dut (
      .clk          (clk),
      .reset        (reset),
      .update_event (update_event),
      .x            (x),
      .y            (y),
      .pixel_color  (pixel_color)
   );

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_y(int i);
      return (i * 60 + 50) / 100;
   endfunction

   function automatic int ref_next(int o);
      int n = o + 4;
      if (100 + n > 639) n = 0;
      return n;
   endfunction

   // One full step; glitch_at >= 0 drops update_event for one cycle at that
   // DRAW index so a fresh rising edge lands mid-draw.
   task automatic test_step(input string nm, input int glitch_at);
      int o2;
      update_event = 1'b1;
      tick();
      drawn = 0;
      for (int i = 0; i <= 100; i++) begin
         n_cmp++;
         if ({x, y, pixel_color} !== {11'(off_m + i), 11'(ref_y(i)), 1'b0}) begin
            n_bad++;
            $display("FAIL %s_erase[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,0)",
                     nm, i, x, y, pixel_color, off_m + i, ref_y(i));
         end else drawn++;
         tick();
      end
      o2 = ref_next(off_m);
      for (int i = 0; i <= 100; i++) begin
         if (i == glitch_at) update_event = 1'b0;
         else if (glitch_at >= 0 && i == glitch_at + 1) update_event = 1'b1;
         n_cmp++;
         if ({x, y, pixel_color} !== {11'(o2 + i), 11'(ref_y(i)), 1'b1} || x >= 11'd640) begin
            n_bad++;
            $display("FAIL %s_draw[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,1)",
                     nm, i, x, y, pixel_color, o2 + i, ref_y(i));
         end else drawn++;
         tick();
      end
      off_m  = o2;
      idle_x = 100 + off_m;
      idle_y = 60;
      idle_c = 1;
      n_cmp++;
      if ({x, y, pixel_color} !== {11'(idle_x), 11'(idle_y), 1'(idle_c)}) begin
         n_bad++;
         $display("FAIL %s_idle: got (%0d,%0d,%0b) want (%0d,%0d,%0d)",
                  nm, x, y, pixel_color, idle_x, idle_y, idle_c);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      update_event = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({x, y, pixel_color} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset[%0d]: got (%0d,%0d,%0b) want (0,0,0)", i, x, y, pixel_color);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_cmp++;
         if ({x, y, pixel_color} !== 23'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle[%0d]: got (%0d,%0d,%0b) want (0,0,0)", i, x, y, pixel_color);
         end
      end
      off_m = 0;
      idle_x = 0; idle_y = 0; idle_c = 0;
   endtask

   task automatic test_first_step();
      test_step("first", -1);
   endtask

   task automatic test_hold_high();
      for (int i = 0; i < 1000; i++) begin
         tick();
         n_cmp++;
         if ({x, y, pixel_color} !== {11'(idle_x), 11'(idle_y), 1'(idle_c)}) begin
            n_bad++;
            $display("FAIL hold_high[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,%0d)",
                     i, x, y, pixel_color, idle_x, idle_y, idle_c);
         end
      end
      update_event = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back_edge();
      int g = int'($urandom_range(0, 98));
      test_step("glitch", g);
      n_cmp++;
      if (drawn !== 202) begin
         n_bad++;
         $display("FAIL glitch_count: got %0d pixels want 202", drawn);
      end
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if ({x, y, pixel_color} !== {11'(idle_x), 11'(idle_y), 1'(idle_c)}) begin
         n_bad++;
         $display("FAIL glitch_no_step: got (%0d,%0d,%0b) want (%0d,%0d,%0d)",
                  x, y, pixel_color, idle_x, idle_y, idle_c);
      end
      update_event = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      reset = 1'b1;
      update_event = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      off_m = 0;
      idle_x = 0; idle_y = 0; idle_c = 0;
      for (int k = 1; k <= 135; k++) begin
         update_event = 1'b0;
         tick();
         n_cmp++;
         if ({x, y, pixel_color} !== {11'(idle_x), 11'(idle_y), 1'(idle_c)}) begin
            n_bad++;
            $display("FAIL wrap_gap[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,%0d)",
                     k, x, y, pixel_color, idle_x, idle_y, idle_c);
         end
         repeat ($urandom_range(0, 3)) tick();
         test_step("wrap", -1);
         if (k == 134) begin
            n_cmp++;
            if (x !== 11'd636) begin
               n_bad++;
               $display("FAIL wrap_134_end_x: got %0d want 636", x);
            end
         end
         if (k == 135) begin
            n_cmp++;
            if (x !== 11'd100) begin
               n_bad++;
               $display("FAIL wrap_135_end_x: got %0d want 100", x);
            end
         end
      end
      update_event = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_erase();
      int n = int'($urandom_range(1, 99));
      update_event = 1'b1;
      tick();
      repeat (n) tick();
      reset = 1'b1;
      update_event = 1'b0;
      tick();
      n_cmp++;
      if ({x, y, pixel_color} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_mid: got (%0d,%0d,%0b) want (0,0,0)", x, y, pixel_color);
      end
      reset = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({x, y, pixel_color} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_mid_idle: got (%0d,%0d,%0b) want (0,0,0)", x, y, pixel_color);
      end
      off_m = 0;
      idle_x = 0; idle_y = 0; idle_c = 0;
      test_step("after_reset", -1);
      update_event = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_first_step();
      test_hold_high();
      test_back_to_back_edge();
      test_wrap();
      test_reset_mid_erase();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
